alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL provide parameter ADDR_W, default 24, meaning the width of the data bus address.
REQ-002 SHALL provide ports, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  block can accept a result.
- in_size  in  1  0 = byte, 1 = word.
- in_dest  in  2  0 = flags only, 1 = register, 2 = memory, 3 = reserved.
- in_reg_sel  in  4  destination register index.
- in_addr  in  ADDR_W  memory destination address.
- in_result  in  16  ALU result R.
- in_flags  in  4  ALU flags: bit0 Z, bit1 C, bit2 V, bit3 S.
- in_flag_mask  in  4  per-bit flag update enable.
- flags_load  in  1  direct flag-register load, e.g. a pop of SC.
- flags_load_data  in  4  value for flags_load.
- flags  out  4  architectural Z/C/V/S register, fed back to the ALU carry input.
- reg_we  out  1  register-file write strobe.
- reg_sel  out  4  register index.
- reg_size  out  1  0 = write low byte only, 1 = write word.
- reg_data  out  16  write data.
- bus_write  out  1  memory write request.
- bus_addr  out  ADDR_W  byte address.
- bus_data  out  8  byte write data.
- bus_ack  in  1  memory write accepted this cycle.
- busy  out  1  transfer in progress.

Function
REQ-003 SHALL accept a result on a rising edge where in_valid and in_ready are both high; inputs are ignored otherwise.
REQ-004 SHALL drive in_ready high only in state IDLE, and low in states MEM_LO and MEM_HI; busy SHALL equal the inverse of in_ready.
REQ-005 SHALL update flags on the accept edge as (flags AND NOT mask) OR (in_flags AND mask), independent of in_dest.
REQ-006 SHALL, when flags_load is high, set flags to flags_load_data; flags_load SHALL take priority over a simultaneous accepted ALU flag update.
REQ-007 SHALL, for an accepted in_dest=1, pulse reg_we high for exactly one cycle, in the cycle following the accept edge, with reg_sel, reg_size and reg_data registered from the accepted inputs; the FSM SHALL remain in IDLE.
REQ-008 SHALL, for an accepted in_dest=1 with in_size=0, drive reg_data[15:8] to 0; the register file ignores those bits.
REQ-009 SHALL, for an accepted in_dest=2, enter MEM_LO with bus_write=1, bus_addr=in_addr and bus_data=in_result[7:0].
REQ-010 SHALL hold bus_write, bus_addr and bus_data stable in MEM_LO and MEM_HI until an edge on which bus_ack=1.
REQ-011 SHALL, on bus_ack in MEM_LO: if word, go to MEM_HI with bus_addr+1 (modulo 2^ADDR_W, so all-ones wraps to 0) and bus_data=result[15:8]; if byte, go to IDLE with bus_write=0.
REQ-012 SHALL, on bus_ack in MEM_HI, go to IDLE with bus_write=0.
REQ-013 SHALL treat in_dest=0 and in_dest=3 as flags-only: no reg_we, no bus_write, and the FSM stays in IDLE.
REQ-014 SHALL ignore bus_ack while in IDLE.
REQ-015 SHALL accept back-to-back results in IDLE on consecutive cycles when in_dest is not 2, producing one reg_we pulse per accepted result.
REQ-016 SHALL leave reg_sel, reg_size and reg_data holding their last values when reg_we=0.

Reset
REQ-017 SHALL, while reset is asserted, force the FSM to IDLE and flags, reg_we, reg_sel, reg_size, reg_data, bus_write, bus_addr and bus_data to 0, with in_ready=1 and busy=0.
REQ-018 SHALL abandon any in-progress memory transfer on reset, with no further bus_write after reset deasserts.

Verification
REQ-019 Register byte: accept dest=1, size=0, sel=3, result=0x12AB, flags=0b0001, mask=0xF -> one cycle later reg_we=1, reg_data=0x00AB, reg_size=0; flags=0x1.
REQ-020 Memory word with wrap: accept dest=2, size=1, addr=0xFFFFFF, result=0xBEEF; bus_ack delayed 2 cycles each -> writes (0xFFFFFF, 0xEF) then (0x000000, 0xBE); in_ready=0 until after the second ack.
REQ-021 Masked flags: with flags=0xF, accept mask=0b0010, in_flags=0 -> flags=0xD; on the same edge, flags_load=1 with data 0x6 -> flags=0x6.
REQ-022 Back-to-back: three dest=1 results on consecutive cycles -> three consecutive reg_we pulses with matching data; with a dest=2 result in flight, in_valid is held high without acceptance until the FSM returns to IDLE.
REQ-023 Reset mid-transfer: assert reset in MEM_HI -> bus_write=0 immediately; after release, in_ready=1, flags=0, and no write occurs.
REQ-024 Flags-only: accept dest=3 -> no reg_we, no bus_write; flags updated per the mask.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU result writeback: updates the Z/C/V/S flag register, issues register-file writes,
// and serialises word results to an 8-bit memory bus as low byte then high byte.
module alu_writeback #(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_size,
    input  logic [1:0]        in_dest,
    input  logic [3:0]        in_reg_sel,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_result,
    input  logic [3:0]        in_flags,
    input  logic [3:0]        in_flag_mask,
    input  logic              flags_load,
    input  logic [3:0]        flags_load_data,
    output logic [3:0]        flags,
    output logic              reg_we,
    output logic [3:0]        reg_sel,
    output logic              reg_size,
    output logic [15:0]       reg_data,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_data,
    input  logic              bus_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StMemLo,
        StMemHi
    } state_e;

    localparam logic [1:0] DestReg = 2'd1;
    localparam logic [1:0] DestMem = 2'd2;

    state_e     state_q;
    logic [7:0] hi_byte_q;
    logic       word_q;
    logic       accept;

    assign in_ready = (state_q == StIdle);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hi_byte_q <= 8'h00;
            word_q    <= 1'b0;
            flags     <= 4'h0;
            reg_we    <= 1'b0;
            reg_sel   <= 4'h0;
            reg_size  <= 1'b0;
            reg_data  <= 16'h0000;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_data  <= 8'h00;
        end else begin
            reg_we <= 1'b0;

            // A direct load (e.g. restoring a saved status word) overrides any ALU update.
            if (flags_load) begin
                flags <= flags_load_data;
            end else if (accept) begin
                flags <= (flags & ~in_flag_mask) | (in_flags & in_flag_mask);
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (in_dest == DestReg) begin
                            reg_we   <= 1'b1;
                            reg_sel  <= in_reg_sel;
                            reg_size <= in_size;
                            reg_data <= in_size ? in_result : {8'h00, in_result[7:0]};
                        end else if (in_dest == DestMem) begin
                            state_q   <= StMemLo;
                            bus_write <= 1'b1;
                            bus_addr  <= in_addr;
                            bus_data  <= in_result[7:0];
                            hi_byte_q <= in_result[15:8];
                            word_q    <= in_size;
                        end
                    end
                end
                StMemLo: begin
                    if (bus_ack) begin
                        if (word_q) begin
                            state_q  <= StMemHi;
                            bus_addr <= bus_addr + ADDR_W'(1);
                            bus_data <= hi_byte_q;
                        end else begin
                            state_q   <= StIdle;
                            bus_write <= 1'b0;
                        end
                    end
                end
                StMemHi: begin
                    if (bus_ack) begin
                        state_q   <= StIdle;
                        bus_write <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    bus_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected register and bus writes are queued at accept
// time and retired by monitors when the DUT emits them.
module tb_alu_writeback;

    localparam int unsigned ADDR_W   = 24;
    localparam int          AckDelay = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_size;
    logic [1:0]        in_dest;
    logic [3:0]        in_reg_sel;
    logic [ADDR_W-1:0] in_addr;
    logic [15:0]       in_result;
    logic [3:0]        in_flags;
    logic [3:0]        in_flag_mask;
    logic              flags_load;
    logic [3:0]        flags_load_data;
    logic [3:0]        flags;
    logic              reg_we;
    logic [3:0]        reg_sel;
    logic              reg_size;
    logic [15:0]       reg_data;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_data;
    logic              bus_ack;
    logic              busy;

    alu_writeback #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_size         (in_size),
        .in_dest         (in_dest),
        .in_reg_sel      (in_reg_sel),
        .in_addr         (in_addr),
        .in_result       (in_result),
        .in_flags        (in_flags),
        .in_flag_mask    (in_flag_mask),
        .flags_load      (flags_load),
        .flags_load_data (flags_load_data),
        .flags           (flags),
        .reg_we          (reg_we),
        .reg_sel         (reg_sel),
        .reg_size        (reg_size),
        .reg_data        (reg_data),
        .bus_write       (bus_write),
        .bus_addr        (bus_addr),
        .bus_data        (bus_data),
        .bus_ack         (bus_ack),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] reg_q[$];   // {sel, size, data}
    logic [31:0] bus_q[$];   // {addr, data}
    logic [3:0]  flags_model = 4'h0;
    logic        idle_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Register-write monitor: every reg_we pulse must retire exactly one queued write.
    always @(negedge clk) begin
        if (!reset && reg_we) begin
            if (reg_q.size() == 0) begin
                check("reg_we_unexpected", 32'd1, 32'd0);
            end else begin
                logic [20:0] e;
                e = reg_q.pop_front();
                check("reg_sel", {28'd0, reg_sel}, {28'd0, e[20:17]});
                check("reg_size", {31'd0, reg_size}, {31'd0, e[16]});
                check("reg_data", {16'd0, reg_data}, {16'd0, e[15:0]});
            end
        end
    end

    // Bus responder: acks each beat after AckDelay sampled cycles and checks the beat is stable.
    int          wait_cnt = 0;
    logic [31:0] cur_beat = '0;
    always @(negedge clk) begin
        if (reset) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (bus_ack) begin
                bus_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (bus_write) begin
                if (wait_cnt == 0) begin
                    if (bus_q.size() == 0) begin
                        check("bus_write_unexpected", 32'd1, 32'd0);
                        cur_beat = {bus_addr, bus_data};
                    end else begin
                        cur_beat = bus_q.pop_front();
                        check("bus_addr", {8'd0, bus_addr}, {8'd0, cur_beat[31:8]});
                        check("bus_data", {24'd0, bus_data}, {24'd0, cur_beat[7:0]});
                    end
                end else begin
                    check("bus_stable", {bus_addr, bus_data}, cur_beat);
                end
                wait_cnt++;
                if (wait_cnt >= AckDelay) bus_ack = 1'b1;
            end else if (idle_ack) begin
                bus_ack = 1'b1;
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following accept.
    task automatic send(input logic [1:0] dest, input logic size, input logic [3:0] sel,
                        input logic [ADDR_W-1:0] addr, input logic [15:0] res,
                        input logic [3:0] fl, input logic [3:0] mask, output int stalls);
        logic [ADDR_W-1:0] a1;
        in_valid     = 1'b1;
        in_dest      = dest;
        in_size      = size;
        in_reg_sel   = sel;
        in_addr      = addr;
        in_result    = res;
        in_flags     = fl;
        in_flag_mask = mask;
        stalls       = 0;
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
            if (!flags_load) check("flags_stall", {28'd0, flags}, {28'd0, flags_model});
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (dest == 2'd1) reg_q.push_back({sel, size, size ? res : {8'h00, res[7:0]}});
        if (dest == 2'd2) begin
            bus_q.push_back({addr, res[7:0]});
            a1 = addr + 24'd1;
            if (size) bus_q.push_back({a1, res[15:8]});
        end
        if (flags_load) flags_model = flags_load_data;
        else flags_model = (flags_model & ~mask) | (fl & mask);
        @(negedge clk);
        in_valid = 1'b0;
        check("flags", {28'd0, flags}, {28'd0, flags_model});
    endtask

    task automatic drain();
        int n = 0;
        while ((!in_ready || bus_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        reset = 1'b1;
        in_valid = 1'b0; in_size = 1'b0; in_dest = 2'd0; in_reg_sel = 4'h0; in_addr = '0;
        in_result = 16'h0; in_flags = 4'h0; in_flag_mask = 4'h0;
        flags_load = 1'b0; flags_load_data = 4'h0; bus_ack = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_reg", {reg_we, reg_sel, reg_size, reg_data}, 32'd0);
        check("rst_bus", {bus_write, bus_addr, bus_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Register byte write
        send(2'd1, 1'b0, 4'd3, '0, 16'h12AB, 4'b0001, 4'hF, st);
        check("rb_we", {31'd0, reg_we}, 32'd1);
        check("rb_data", {16'd0, reg_data}, 32'h00AB);
        check("rb_size", {31'd0, reg_size}, 32'd0);
        check("rb_flags", {28'd0, flags}, 32'h1);
        @(negedge clk);
        check("rb_we_once", {31'd0, reg_we}, 32'd0);
        check("rb_hold", {16'd0, reg_data}, 32'h00AB);

        // Memory word with address wrap, then a register result held off until idle
        send(2'd2, 1'b1, 4'd0, 24'hFFFFFF, 16'hBEEF, 4'h0, 4'h0, st);
        check("mw_busy", {31'd0, busy}, 32'd1);
        send(2'd1, 1'b1, 4'd5, '0, 16'h1234, 4'h0, 4'h0, st);
        check("mw_stalls", st, 32'd4);
        // Memory byte: a single beat
        send(2'd2, 1'b0, 4'd0, 24'h000100, 16'h5A3C, 4'h0, 4'h0, st);
        send(2'd0, 1'b0, 4'd0, '0, 16'h0, 4'h0, 4'h0, st);
        check("mb_stalls", st, 32'd2);

        // Back-to-back register writes
        send(2'd1, 1'b1, 4'd1, '0, 16'hA001, 4'h0, 4'h0, st);
        check("b2b_we0", {31'd0, reg_we}, 32'd1);
        send(2'd1, 1'b0, 4'd2, '0, 16'hB0C2, 4'h0, 4'h0, st);
        check("b2b_we1", {31'd0, reg_we}, 32'd1);
        send(2'd1, 1'b1, 4'd4, '0, 16'hC003, 4'h0, 4'h0, st);
        check("b2b_we2", {31'd0, reg_we}, 32'd1);
        check("b2b_stalls", st, 32'd0);

        // Masked flags and load priority
        send(2'd0, 1'b0, 4'd0, '0, 16'h0, 4'hF, 4'hF, st);
        send(2'd3, 1'b0, 4'd0, '0, 16'h0, 4'h0, 4'b0010, st);
        check("mask_flags", {28'd0, flags}, 32'hD);
        flags_load = 1'b1; flags_load_data = 4'h6;
        send(2'd0, 1'b0, 4'd0, '0, 16'h0, 4'h0, 4'hF, st);
        check("load_prio", {28'd0, flags}, 32'h6);
        flags_load_data = 4'h9;
        flags_model = 4'h9;
        @(negedge clk);
        flags_load = 1'b0;
        check("load_alone", {28'd0, flags}, 32'h9);

        // Flags-only reserved destination, with stray acks while idle
        idle_ack = 1'b1;
        send(2'd3, 1'b1, 4'd7, 24'h000010, 16'hFFFF, 4'b0110, 4'b0101, st);
        check("dest3_flags", {28'd0, flags}, 32'hC);
        repeat (3) @(negedge clk);
        check("idle_ack_ready", {31'd0, in_ready}, 32'd1);
        idle_ack = 1'b0;
        @(negedge clk);

        // Random mix
        for (int i = 0; i < 24; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), ADDR_W'($urandom),
                 16'($urandom), 4'($urandom), 4'($urandom), st);
        end
        drain();

        // Reset while the high byte is pending
        send(2'd2, 1'b1, 4'd0, 24'h123456, 16'hCAFE, 4'h0, 4'h0, st);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", {8'd0, bus_addr}, 32'h123457);
        #2 reset = 1'b1;
        #1;
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        flags_model = 4'h0;
        check("post_rst_flags", {28'd0, flags}, 32'd0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_write", {31'd0, bus_write}, 32'd0);
        end

        check("reg_q_empty", reg_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
